// File: rtl/regfile_pkg.sv
// Shared constants and the per-byte merge rule used by both the write path
// and the read bypass, so stored data and forwarded data always agree.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NBYTES     = DEF_DATA_W / 8;

    typedef logic [7:0] byte_t;

    // Port 1 wins over port 0 on a byte both ports enable.
    function automatic byte_t byte_merge(
        input byte_t old,
        input byte_t d0,
        input logic  be0,
        input logic  en0,
        input byte_t d1,
        input logic  be1,
        input logic  en1
    );
        byte_t res;
        if (en1 && be1) begin
            res = d1;
        end else if (en0 && be0) begin
            res = d0;
        end else begin
            res = old;
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_dual_wb_if.sv
// Read, write-back and issue signals of the dual write-back register file.
interface regfile_dual_wb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0]   rna;
    logic [ADDR_W-1:0]   rnb;
    logic [DATA_W-1:0]   qa;
    logic [DATA_W-1:0]   qb;
    logic                wreg0;
    logic [ADDR_W-1:0]   wn0;
    logic [DATA_W-1:0]   datain0;
    logic [DATA_W/8-1:0] wbe0;
    logic                wreg1;
    logic [ADDR_W-1:0]   wn1;
    logic [DATA_W-1:0]   datain1;
    logic [DATA_W/8-1:0] wbe1;
    logic                issue;
    logic [ADDR_W-1:0]   issue_rd;
    logic                busy_a;
    logic                busy_b;
    logic                wr_conflict;

    modport master (
        output rna, rnb, wreg0, wn0, datain0, wbe0,
               wreg1, wn1, datain1, wbe1, issue, issue_rd,
        input  qa, qb, busy_a, busy_b, wr_conflict
    );

    modport slave (
        input  rna, rnb, wreg0, wn0, datain0, wbe0,
               wreg1, wn1, datain1, wbe1, issue, issue_rd,
        output qa, qb, busy_a, busy_b, wr_conflict
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue marks a register outstanding, a write-back
// clears it; a same-cycle issue beats the write-back.
module regfile_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr0,
    input  logic [ADDR_W-1:0] i_clr0_addr,
    input  logic              i_clr1,
    input  logic [ADDR_W-1:0] i_clr1_addr,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic [ADDR_W-1:0] i_rna,
    input  logic [ADDR_W-1:0] i_rnb,
    output logic              o_busy_a,
    output logic              o_busy_b
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic             w_set_ok;
    logic             w_wb_a;
    logic             w_wb_b;

    // Next busy vector: set has priority over clear.
    always_comb begin
        w_set_ok   = i_set && (!ZERO_REG || (i_set_addr != {ADDR_W{1'b0}}));
        w_busy_nxt = r_busy;
        for (int r = 0; r < DEPTH; r++) begin
            if (w_set_ok && (i_set_addr == ADDR_W'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end else if ((i_clr0 && (i_clr0_addr == ADDR_W'(r))) ||
                         (i_clr1 && (i_clr1_addr == ADDR_W'(r)))) begin
                w_busy_nxt[r] = 1'b0;
            end else begin
                w_busy_nxt[r] = r_busy[r];
            end
        end
    end

    // Lookups; a write-back landing this cycle already resolves the hazard.
    always_comb begin
        w_wb_a   = (i_clr0 && (i_clr0_addr == i_rna)) || (i_clr1 && (i_clr1_addr == i_rna));
        w_wb_b   = (i_clr0 && (i_clr0_addr == i_rnb)) || (i_clr1 && (i_clr1_addr == i_rnb));
        o_busy_a = r_busy[i_rna] && !(BYPASS && w_wb_a);
        o_busy_b = r_busy[i_rnb] && !(BYPASS && w_wb_b);
    end

    // Busy vector register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= {DEPTH{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_dual_wb.sv
// Register file with two read ports, two byte-enabled write-back ports
// (port 1 wins), optional same-cycle bypass and a busy scoreboard.
module regfile_dual_wb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    regfile_dual_wb_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_conflict;

    logic              w_act0;
    logic              w_act1;
    logic              w_same_addr;
    logic [DATA_W-1:0] w_wdata0;
    logic [DATA_W-1:0] w_wdata1;
    logic [DATA_W-1:0] w_byp_a;
    logic [DATA_W-1:0] w_byp_b;
    logic [DATA_W-1:0] w_qa;
    logic [DATA_W-1:0] w_qb;

    function automatic logic [DATA_W-1:0] merge_row(
        input logic [DATA_W-1:0] old,
        input logic              hit0,
        input logic              hit1,
        input logic [DATA_W-1:0] d0,
        input logic [NB-1:0]     be0,
        input logic [DATA_W-1:0] d1,
        input logic [NB-1:0]     be1
    );
        logic [DATA_W-1:0] res;
        res = old;
        for (int b = 0; b < NB; b++) begin
            res[8*b +: 8] = byte_merge(old[8*b +: 8], d0[8*b +: 8], be0[b], hit0,
                                       d1[8*b +: 8], be1[b], hit1);
        end
        return res;
    endfunction

    // Port activity: an empty byte mask or a write to the hardwired r0 is a no-op.
    always_comb begin
        w_act0      = bus.wreg0 && (bus.wbe0 != {NB{1'b0}}) &&
                      (!ZERO_REG || (bus.wn0 != {ADDR_W{1'b0}}));
        w_act1      = bus.wreg1 && (bus.wbe1 != {NB{1'b0}}) &&
                      (!ZERO_REG || (bus.wn1 != {ADDR_W{1'b0}}));
        w_same_addr = (bus.wn0 == bus.wn1);
    end

    // Merged next values for both write targets and both read addresses.
    always_comb begin
        w_wdata0 = merge_row(r_mem[bus.wn0], w_act0, w_act1 && w_same_addr,
                             bus.datain0, bus.wbe0, bus.datain1, bus.wbe1);
        w_wdata1 = merge_row(r_mem[bus.wn1], w_act0 && w_same_addr, w_act1,
                             bus.datain0, bus.wbe0, bus.datain1, bus.wbe1);
        w_byp_a  = merge_row(r_mem[bus.rna], w_act0 && (bus.wn0 == bus.rna),
                             w_act1 && (bus.wn1 == bus.rna),
                             bus.datain0, bus.wbe0, bus.datain1, bus.wbe1);
        w_byp_b  = merge_row(r_mem[bus.rnb], w_act0 && (bus.wn0 == bus.rnb),
                             w_act1 && (bus.wn1 == bus.rnb),
                             bus.datain0, bus.wbe0, bus.datain1, bus.wbe1);
    end

    // Read port A.
    always_comb begin
        if (ZERO_REG && (bus.rna == {ADDR_W{1'b0}})) begin
            w_qa = {DATA_W{1'b0}};
        end else if (BYPASS) begin
            w_qa = w_byp_a;
        end else begin
            w_qa = r_mem[bus.rna];
        end
    end

    // Read port B.
    always_comb begin
        if (ZERO_REG && (bus.rnb == {ADDR_W{1'b0}})) begin
            w_qb = {DATA_W{1'b0}};
        end else if (BYPASS) begin
            w_qb = w_byp_b;
        end else begin
            w_qb = r_mem[bus.rnb];
        end
    end

    assign bus.qa          = w_qa;
    assign bus.qb          = w_qb;
    assign bus.wr_conflict = r_wr_conflict;

    // Storage and overlap flag; on a shared target both ports carry the same merged row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
            r_wr_conflict <= 1'b0;
        end else begin
            if (w_act0) begin
                r_mem[bus.wn0] <= w_wdata0;
            end
            if (w_act1) begin
                r_mem[bus.wn1] <= w_wdata1;
            end
            r_wr_conflict <= w_act0 && w_act1 && w_same_addr &&
                             ((bus.wbe0 & bus.wbe1) != {NB{1'b0}});
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_clr0      (w_act0),
        .i_clr0_addr (bus.wn0),
        .i_clr1      (w_act1),
        .i_clr1_addr (bus.wn1),
        .i_set       (bus.issue),
        .i_set_addr  (bus.issue_rd),
        .i_rna       (bus.rna),
        .i_rnb       (bus.rnb),
        .o_busy_a    (bus.busy_a),
        .o_busy_b    (bus.busy_b)
    );

endmodule

// File: tb/tb_regfile_dual_wb.sv
// Directed vector bench: one bypassing and one non-bypassing instance share
// the same stimulus; the reset corner is a hand-written sequence.
module tb_regfile_dual_wb;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    regfile_dual_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_dual_wb_if #(.DATA_W(32), .ADDR_W(5)) bus_nb ();

    regfile_dual_wb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    regfile_dual_wb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        w0;  logic [4:0] wn0; logic [31:0] d0; logic [3:0] be0;
        logic        w1;  logic [4:0] wn1; logic [31:0] d1; logic [3:0] be1;
        logic        iss; logic [4:0] ird;
        logic [4:0]  rna; logic [4:0] rnb;
        logic [31:0] qa;  logic [31:0] qb; logic ba; logic bb; logic conf;
        logic [31:0] qa_nb; logic ba_nb;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic apply(input vec_t v);
        bus.wreg0 = v.w0;     bus.wn0 = v.wn0;     bus.datain0 = v.d0;     bus.wbe0 = v.be0;
        bus.wreg1 = v.w1;     bus.wn1 = v.wn1;     bus.datain1 = v.d1;     bus.wbe1 = v.be1;
        bus.issue = v.iss;    bus.issue_rd = v.ird; bus.rna = v.rna;       bus.rnb = v.rnb;
        bus_nb.wreg0 = v.w0;  bus_nb.wn0 = v.wn0;  bus_nb.datain0 = v.d0;  bus_nb.wbe0 = v.be0;
        bus_nb.wreg1 = v.w1;  bus_nb.wn1 = v.wn1;  bus_nb.datain1 = v.d1;  bus_nb.wbe1 = v.be1;
        bus_nb.issue = v.iss; bus_nb.issue_rd = v.ird; bus_nb.rna = v.rna; bus_nb.rnb = v.rnb;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t idle(input logic [4:0] a, input logic [4:0] b);
        vec_t v;
        v = '{1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0,
              a, b, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        return v;
    endfunction

    initial begin
        vec_t v;
        errors = 0;
        checks = 0;

        //           w0    wn0    d0            be0   w1    wn1    d1            be1   iss   ird    rna    rnb    qa            qb            ba    bb    conf  qa_nb         ba_nb
        vecs[0]  = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd5,  5'd0,  32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 4'hF, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd5,  5'd3,  32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 5'd0,  32'h12345678, 4'hF, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b1, 5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b1, 5'd3,  32'h11111111, 4'hF, 1'b1, 5'd3,  32'h22222222, 4'h3, 1'b0, 5'd0,  5'd3,  5'd5,  32'h11112222, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd3,  5'd3,  32'h11112222, 32'h11112222, 1'b0, 1'b0, 1'b1, 32'h11112222, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd3,  5'd0,  32'h11112222, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h11112222, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b1, 5'd7,  5'd7,  5'd7,  32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd7,  5'd3,  32'h00000000, 32'h11112222, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b1, 5'd7,  32'hAABBCCDD, 4'h1, 1'b0, 5'd0,  5'd7,  5'd9,  32'h000000DD, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd7,  5'd7,  32'h000000DD, 32'h000000DD, 1'b0, 1'b0, 1'b0, 32'h000000DD, 1'b0};
        vecs[12] = '{1'b1, 5'd7,  32'h12345678, 4'hF, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b1, 5'd7,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h000000DD, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd7,  5'd9,  32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b1};
        vecs[14] = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b1, 5'd9,  32'h55667788, 4'hF, 1'b1, 5'd9,  5'd9,  5'd7,  32'h55667788, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
        vecs[15] = '{1'b1, 5'd9,  32'hFFFFFFFF, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd9,  5'd7,  32'h55667788, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h55667788, 1'b1};
        vecs[16] = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd9,  5'd9,  32'h55667788, 32'h55667788, 1'b1, 1'b1, 1'b0, 32'h55667788, 1'b1};
        vecs[17] = '{1'b1, 5'd5,  32'h01020304, 4'hC, 1'b1, 5'd9,  32'hA0B0C0D0, 4'h6, 1'b0, 5'd0,  5'd5,  5'd9,  32'h0102BEEF, 32'h55B0C088, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[18] = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd5,  5'd9,  32'h0102BEEF, 32'h55B0C088, 1'b0, 1'b0, 1'b0, 32'h0102BEEF, 1'b0};
        vecs[19] = '{1'b1, 5'd3,  32'h000000EE, 4'h1, 1'b1, 5'd3,  32'h0000FF00, 4'h2, 1'b0, 5'd0,  5'd3,  5'd7,  32'h1111FFEE, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h11112222, 1'b0};
        vecs[20] = '{1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  5'd3,  5'd7,  32'h1111FFEE, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h1111FFEE, 1'b0};

        reset = 1'b1;
        apply(idle(5'd0, 5'd0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            apply(vecs[i]);
            #1;
            chk("qa",          i, bus.qa,                    vecs[i].qa);
            chk("qb",          i, bus.qb,                    vecs[i].qb);
            chk("busy_a",      i, {31'd0, bus.busy_a},       {31'd0, vecs[i].ba});
            chk("busy_b",      i, {31'd0, bus.busy_b},       {31'd0, vecs[i].bb});
            chk("wr_conflict", i, {31'd0, bus.wr_conflict},  {31'd0, vecs[i].conf});
            chk("qa_nobyp",    i, bus_nb.qa,                 vecs[i].qa_nb);
            chk("busy_a_nobyp",i, {31'd0, bus_nb.busy_a},    {31'd0, vecs[i].ba_nb});
        end

        // Overlapping write to r5, then an asynchronous reset between edges.
        @(negedge clk);
        v = idle(5'd5, 5'd7);
        v.w0 = 1'b1; v.wn0 = 5'd5; v.d0 = 32'hFFFFFFFF; v.be0 = 4'hF;
        v.w1 = 1'b1; v.wn1 = 5'd5; v.d1 = 32'h0BADF00D; v.be1 = 4'hF;
        apply(v);
        #1;
        chk("rst_pre_byp", 0, bus.qa, 32'h0BADF00D);
        @(negedge clk);
        apply(idle(5'd5, 5'd7));
        #1;
        chk("rst_pre_qa",   0, bus.qa,                   32'h0BADF00D);
        chk("rst_pre_conf", 0, {31'd0, bus.wr_conflict}, 32'd1);
        chk("rst_pre_busy", 0, {31'd0, bus.busy_b},      32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_qa",      0, bus.qa,                   32'h00000000);
        chk("rst_qa_nb",   0, bus_nb.qa,                32'h00000000);
        chk("rst_busy_b",  0, {31'd0, bus.busy_b},      32'd0);
        chk("rst_conf",    0, {31'd0, bus.wr_conflict}, 32'd0);
        v = idle(5'd5, 5'd7);
        v.w0 = 1'b1; v.wn0 = 5'd5; v.d0 = 32'h12121212; v.be0 = 4'hF;
        apply(v);
        @(negedge clk);
        reset = 1'b0;
        apply(idle(5'd5, 5'd7));
        #1;
        chk("rst_discard", 0, bus.qa,                   32'h00000000);
        chk("rst_conf",    1, {31'd0, bus.wr_conflict}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_discard", 1, bus_nb.qa,                32'h00000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dual_wb.md
Name: regfile_dual_wb

Overview:
- Parametrised successor of the single-write CPU register file.
- Two read ports and two write-back ports, with per-byte write enables.
- Write-to-read bypass within the same cycle.
- Per-register busy scoreboard, so the decode stage can detect RAW hazards in the planned dual-issue/multi-cycle datapath.

Parameters:
- DATA_W, 32: register width in bits; must be a multiple of 8.
- ADDR_W, 5: register address width; depth = 2**ADDR_W.
- ZERO_REG, 1: 1 = register 0 hardwired to zero, never written, never busy.
- BYPASS, 1: 1 = same-cycle write data is forwarded to the read ports and to busy_a/busy_b.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rna  in  ADDR_W  read port A address
- rnb  in  ADDR_W  read port B address
- qa  out  DATA_W  read port A data (combinational)
- qb  out  DATA_W  read port B data (combinational)
- wreg0  in  1  write port 0 enable
- wn0  in  ADDR_W  write port 0 address
- datain0  in  DATA_W  write port 0 data
- wbe0  in  DATA_W/8  write port 0 byte enables
- wreg1, wn1, datain1, wbe1: write port 1, same widths as port 0; higher priority
- issue  in  1  mark destination register busy
- issue_rd  in  ADDR_W  register to mark busy
- busy_a  out  1  scoreboard status of rna
- busy_b  out  1  scoreboard status of rnb
- wr_conflict  out  1  registered flag: both ports wrote overlapping bytes of one register last cycle

Behaviour:
- Reset, asynchronous, takes effect immediately on assertion:
  - all registers = 0, all busy bits = 0, wr_conflict = 0.
  - Reset asserted mid-operation discards any in-flight write.
- Port activity: a write port is active when wregX=1, wbeX!=0 and (ZERO_REG=0 or wnX!=0).
  - wregX=1 with wbeX=0 does nothing: no write, no busy clear.
- Write, at posedge clk:
  - For each byte b of register r: if port 1 is active, wn1=r and wbe1[b], the byte takes datain1.
  - Else if port 0 is active, wn0=r and wbe0[b], the byte takes datain0.
  - Else the byte keeps its value.
  - Write latency is 1 cycle.
- Read:
  - qa = register[rna], combinational, 0-cycle latency.
  - If ZERO_REG and rna=0, qa=0.
  - If BYPASS=1, qa shows the byte-merged next value of register[rna] when either write port is active on rna in the same cycle, using the same per-byte priority as the write.
  - qb follows identical rules with rnb.
- Scoreboard:
  - At posedge, any active write to r clears busy[r].
  - issue=1 sets busy[issue_rd]. If the issue and a write hit the same register in one cycle, set wins: the new producer is outstanding.
  - If ZERO_REG and issue_rd=0, issue is ignored.
  - busy_a = busy[rna]. If BYPASS=1 and an active write targets rna this cycle, busy_a=0. busy_b is the same with rnb.
- wr_conflict:
  - Set to 1 for exactly one cycle after a cycle in which both ports were active, wn0=wn1 and (wbe0 & wbe1)!=0.
  - Otherwise 0.
  - This flag is diagnostic only; the write still completes with port-1 priority.
- Out-of-range behaviour: none; all 2**ADDR_W addresses are valid.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W/ADDR_W constants
  - NBYTES = DATA_W/8
  - function byte_merge(old, d0, be0, en0, d1, be1, en1), used both by the write path and the bypass path so they cannot diverge.
- Sub-module regfile_scoreboard: the 2**ADDR_W busy vector with set/clear logic and the two lookups.
- The storage array and bypass logic stay in the top module.

Test Plan:
- Reset: preload r5=0xDEADBEEF, assert reset between clock edges -> qa(rna=5)=0 immediately, busy_a=0, wr_conflict=0.
- Zero register: write r0=0x12345678 on port 0 with wbe0=0xF; issue with issue_rd=0 -> qa(rna=0)=0, busy_a=0.
- Priority merge:
  - Stimulus: r3=0x00000000; in the same cycle, port 0 writes 0x11111111 with wbe0=0xF and port 1 writes 0x22222222 with wbe1=0x3.
  - Response: same-cycle bypass qa(rna=3)=0x11112222; after the edge r3=0x11112222; next cycle wr_conflict=1; the cycle after, wr_conflict=0.
- Bypass off: with BYPASS=0, the same write shows qa=old value during the write cycle and the new value after the edge.
- Scoreboard:
  - issue r7 -> busy_a(rna=7)=1.
  - Port 1 writes r7 with wbe1=0x1 -> busy_a=0 combinationally, and busy[7]=0 after the edge.
  - Issue r7 together with a port 0 write to r7 -> busy[7]=1 after the edge.
- Null write: wreg0=1 with wbe0=0 to r9 while busy[9]=1 -> r9 unchanged and busy[9] stays 1.
